data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder: the memory end of the core's load/store path.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Performs byte/half/word accesses on an internal word-wide RAM, including
//  sub-word read-modify-write for stores, and returns sign/zero-extended load
//  data or an error flag over a valid/ready response channel.
// PARAMETERS
//  DEPTH_WORDS   1024  RAM size in 32-bit words (power of 2, >=4)
//  ACCESS_LAT    1     cycles spent in ACCESS state, legal range 1..4
//  BASE_ADDR     0     byte address mapped to RAM word 0 (word aligned)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset
//  req_valid     in   1   request present
//  req_ready     out  1   responder can accept a request
//  req_we        in   1   1=store, 0=load
//  req_addr      in   32  byte address
//  req_size      in   2   00=byte, 01=half, 10=word, 11=illegal
//  req_unsigned  in   1   load only: 1=zero-extend (lbu/lhu), 0=sign-extend
//  req_wdata     in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   consumer accepts response
//  rsp_rdata     out  32  extended load data; 0 for stores and errors
//  rsp_err       out  1   misaligned, out-of-range or illegal-size request
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency count=0.
//  RAM is not cleared by rst (zero at time 0); a store not yet committed when
//   rst asserts is dropped.
//  req_ready = (state==IDLE) & ~rst, combinational. One request outstanding max.
//  FSM: IDLE -(req_valid&req_ready)-> ACCESS; fields latched at that edge.
//   ACCESS holds ACCESS_LAT cycles (counter 0..ACCESS_LAT-1) -> RESPOND.
//   RESPOND holds rsp_valid=1, rdata/err stable -(rsp_ready)-> IDLE.
//  Latency: accept at edge E0 -> rsp_valid high after edge E(ACCESS_LAT).
//   If rsp_ready is already 1, the response completes at the following edge.
//   The next request is accepted one cycle later (IDLE bubble, no overlap).
//  Error checks, evaluated on latched fields:
//   size=11, or half with addr[0]=1, or word with addr[1:0]!=0, or
//   addr<BASE_ADDR, or ((addr-BASE_ADDR)>>2)>=DEPTH_WORDS.
//   Error: rsp_err=1, rsp_rdata=0, RAM unchanged.
//  Word index = (addr-BASE_ADDR)>>2 (32-bit subtract); lane = addr[1:0].
//  Load: byte from lane*8, half from lane[1]*16; bit 7/15 extended unless
//   req_unsigned; word returned whole. rsp_rdata is registered on the last
//   ACCESS edge.
//  Store: only the addressed byte lanes are written (write mask derived from
//   size and lane); other lanes keep their old value. Commit occurs on the
//   last ACCESS edge. rsp_err=0, rsp_rdata=0.
//  Load after store to the same word sees the stored data (stores commit
//   before RESPOND).
//  req_* changes while busy are ignored. rsp_ready while not in RESPOND has
//   no effect.
// TESTING
//  1. Reset, then sw 0xDEADBEEF to 0x10, lw 0x10 -> rdata=0xDEADBEEF, err=0,
//     rsp_valid ACCESS_LAT edges after accept.
//  2. After 1: sb 0x7F to 0x12, lb 0x12 -> 0x0000007F; lw 0x10 -> 0xDE7FBEEF;
//     lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
//  3. sh 0x8001 to 0x22, lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001;
//     lw 0x20 has [15:0] unchanged.
//  4. lh 0x21, sw 0x22, size=11, addr=BASE_ADDR+4*DEPTH_WORDS -> each gives
//     err=1, rdata=0, and a later lw shows the RAM unchanged.
//  5. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0,
//     a new req_valid is not accepted.
//  6. Assert rst during ACCESS of sw 0x1234 to 0x30 -> outputs return to reset
//     values next cycle, and lw 0x30 returns the old value.

Source files
------------

// File: rtl/data_mem_if.sv
// Load/store request and response channel between the core and the data memory.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: single-outstanding load/store engine on a word RAM
// with byte/half/word lanes, sub-word read-modify-write and load extension.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          ACCESS_LAT  = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic      clk,
    input  logic      rst,
    data_mem_if.slave bus_if
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAST_CNT = 2'(ACCESS_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic        last_access;
    logic [31:0] off;
    logic [1:0]  lane;
    logic [AW-1:0] widx;
    logic        req_err;
    logic [31:0] rd_word;
    logic [3:0]  wmask;
    logic [31:0] wlanes;

    // Pick the addressed byte/half out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] ln,
                                                input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Byte-lane write enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] ln);
        case (sz)
            2'b00:   return 4'b0001 << ln;
            2'b01:   return ln[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign accept      = bus_if.req_valid && bus_if.req_ready;
    assign last_access = (state_q == ACCESS) && (cnt_q == LAST_CNT);

    // Address decode and error checks on the latched request fields.
    assign off     = addr_q - BASE_ADDR;
    assign lane    = off[1:0];
    assign widx    = off[AW+1:2];
    assign req_err = (size_q == 2'b11)
                  || (size_q == 2'b01 && lane[0])
                  || (size_q == 2'b10 && lane != 2'b00)
                  || (addr_q < BASE_ADDR)
                  || (off[31:2] >= 30'(DEPTH_WORDS));
    assign rd_word = mem_q[widx];
    assign wmask   = store_mask(size_q, lane);
    assign wlanes  = (size_q == 2'b00) ? {4{wdata_q[7:0]}}  :
                     (size_q == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)           state_d = ACCESS;
            ACCESS:  if (last_access)      state_d = RESPOND;
            RESPOND: if (bus_if.rsp_ready) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus_if.req_ready = (state_q == IDLE) && !rst;
        bus_if.rsp_valid = (state_q == RESPOND);
    end

    assign bus_if.rsp_rdata = rsp_rdata_q;
    assign bus_if.rsp_err   = rsp_err_q;

    // Latency counter and registered response; both cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            cnt_q <= last_access ? 2'd0 : cnt_q + 2'd1;
            if (last_access) begin
                rsp_err_q   <= req_err;
                rsp_rdata_q <= (req_err || we_q) ? 32'h0 : load_extend(rd_word, lane, size_q, uns_q);
            end
        end
    end

    // Request fields captured on acceptance and held while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus_if.req_we;
            addr_q  <= bus_if.req_addr;
            size_q  <= bus_if.req_size;
            uns_q   <= bus_if.req_unsigned;
            wdata_q <= bus_if.req_wdata;
        end
    end

    // Store commit on the last ACCESS edge; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!rst && last_access && we_q && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem_q[widx][b*8 +: 8] <= wlanes[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus backpressure and
// reset-during-access sequences.
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    data_mem_if bus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .ACCESS_LAT(LAT), .BASE_ADDR(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; lat = edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output bit ok);
        int guard;
        ok = 1'b1; lat = 0; rd = 32'h0; er = 1'b0; guard = 0;
        @(negedge clk);
        bus.req_we = we; bus.req_addr = addr; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_wdata = wd;
        bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            ok = 1'b0;
            return;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        xact(v.we, v.addr, v.size, v.uns, v.wdata, rd, er, lat, ok);
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL %s timeout: no handshake within bound", nm);
        end else begin
            chk({nm, " rdata"}, rd, v.exp_rd);
            chk({nm, " err"}, {31'h0, er}, {31'h0, v.exp_err});
            chk({nm, " latency"}, 32'(lat), 32'(LAT));
        end
    endtask

    initial begin
        // we, addr, size, uns, wdata, exp_rd, exp_err
        vq.push_back('{1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0});
        vq.push_back('{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0});
        vq.push_back('{1'b1, 32'h12, 2'b00, 1'b0, 32'h0000007F, 32'h0,        1'b0});
        vq.push_back('{1'b0, 32'h12, 2'b00, 1'b0, 32'h0,        32'h0000007F, 1'b0});
        vq.push_back('{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDE7FBEEF, 1'b0});
        vq.push_back('{1'b0, 32'h13, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0});
        vq.push_back('{1'b0, 32'h13, 2'b00, 1'b1, 32'h0,        32'h000000DE, 1'b0});
        vq.push_back('{1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0});
        vq.push_back('{1'b1, 32'h22, 2'b01, 1'b0, 32'h12348001, 32'h0,        1'b0});
        vq.push_back('{1'b0, 32'h22, 2'b01, 1'b0, 32'h0,        32'hFFFF8001, 1'b0});
        vq.push_back('{1'b0, 32'h22, 2'b01, 1'b1, 32'h0,        32'h00008001, 1'b0});
        vq.push_back('{1'b0, 32'h20, 2'b10, 1'b0, 32'h0,        32'h8001F00D, 1'b0});
        vq.push_back('{1'b0, 32'h20, 2'b01, 1'b0, 32'h0,        32'hFFFFF00D, 1'b0});
        vq.push_back('{1'b1, 32'h14, 2'b00, 1'b0, 32'h0000AB80, 32'h0,        1'b0});
        vq.push_back('{1'b0, 32'h14, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0});
        vq.push_back('{1'b1, 32'hFC, 2'b10, 1'b0, 32'h13579BDF, 32'h0,        1'b0});
        vq.push_back('{1'b0, 32'hFC, 2'b10, 1'b0, 32'h0,        32'h13579BDF, 1'b0});
        vq.push_back('{1'b0, 32'h21, 2'b01, 1'b0, 32'h0,        32'h0,        1'b1});
        vq.push_back('{1'b1, 32'h22, 2'b10, 1'b0, 32'h11111111, 32'h0,        1'b1});
        vq.push_back('{1'b1, 32'h10, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1});
        vq.push_back('{1'b0, 32'h10, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1});
        vq.push_back('{1'b1, 32'h100, 2'b10, 1'b0, 32'h22222222, 32'h0,       1'b1});
        vq.push_back('{1'b0, 32'h100, 2'b10, 1'b0, 32'h0,       32'h0,        1'b1});
        vq.push_back('{1'b0, 32'hFFFFFFFC, 2'b10, 1'b0, 32'h0,  32'h0,        1'b1});
        vq.push_back('{1'b0, 32'h20, 2'b10, 1'b0, 32'h0,        32'h8001F00D, 1'b0});
        vq.push_back('{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDE7FBEEF, 1'b0});
        vq.push_back('{1'b0, 32'hFC, 2'b10, 1'b0, 32'h0,        32'h13579BDF, 1'b0});
        vq.push_back('{1'b1, 32'h30, 2'b10, 1'b0, 32'h0BADF00D, 32'h0,        1'b0});
        vq.push_back('{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDE7FBEEF, 1'b0});

        // Reset state
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
        bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready low in rst", {31'h0, bus.req_ready}, 32'h0);
        chk("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("reset rsp_err", {31'h0, bus.rsp_err}, 32'h0);

        foreach (vq[i]) run_vec($sformatf("vec%0d", i), vq[i]);

        // Backpressure: hold rsp_ready low, try to sneak in a store
        begin
            int guard;
            guard = 0;
            @(negedge clk);
            bus.req_we = 1'b0; bus.req_addr = 32'h10; bus.req_size = 2'b10;
            bus.req_unsigned = 1'b0; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            while (!bus.rsp_valid && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("bp rsp_valid reached", {31'h0, bus.rsp_valid}, 32'h1);
            bus.req_we = 1'b1; bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                chk($sformatf("bp c%0d rsp_valid", c), {31'h0, bus.rsp_valid}, 32'h1);
                chk($sformatf("bp c%0d rdata", c), bus.rsp_rdata, 32'hDE7FBEEF);
                chk($sformatf("bp c%0d req_ready", c), {31'h0, bus.req_ready}, 32'h0);
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp release rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
            chk("bp release req_ready", {31'h0, bus.req_ready}, 32'h1);
        end
        run_vec("bp lw 0x10 unchanged", '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDE7FBEEF, 1'b0});

        // Reset during ACCESS of a store drops it
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_wdata = 32'h00001234;
        bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
        chk("rst6 req_ready before accept", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst6 rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst6 rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst6 rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("rst6 req_ready in rst", {31'h0, bus.req_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst6 req_ready after rst", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1;
        chk("rst6 still idle", {31'h0, bus.rsp_valid}, 32'h0);
        run_vec("rst6 lw 0x30 old", '{1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
